// File: rtl/two_bit_adder_full_adder.sv
// One-bit combinational full adder; the ripple stage of two_bit_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/two_bit_adder.sv
// Registered 2-bit ripple-carry adder exposing both sum bits, the internal
// bit-0 carry and the final carry-out, all with one cycle of latency.
module two_bit_adder (
  input  logic clk,
  input  logic rst,
  output logic S0,
  output logic S1,
  output logic Cout0,
  output logic Cout1,
  input  logic A0,
  input  logic A1,
  input  logic B0,
  input  logic B1,
  input  logic Cin
);

  logic s0_d, s1_d, c0_d, c1_d;
  logic s0_q, s1_q, c0_q, c1_q;

  full_adder u_fa0 (
    .a    (A0),
    .b    (B0),
    .cin  (Cin),
    .sum  (s0_d),
    .cout (c0_d)
  );

  // Bit 1 takes the bit-0 carry directly: plain ripple, no lookahead.
  full_adder u_fa1 (
    .a    (A1),
    .b    (B1),
    .cin  (c0_d),
    .sum  (s1_d),
    .cout (c1_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
      c0_q <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
    end
  end

  assign S0    = s0_q;
  assign S1    = s1_q;
  assign Cout0 = c0_q;
  assign Cout1 = c1_q;

endmodule

// File: tb/tb_two_bit_adder.sv
// Scoreboard bench for two_bit_adder: the driver queues expected
// {Cout1,Cout0,S1,S0} per cycle, and the monitor checks it after each edge.
module tb_two_bit_adder;

  logic clk;
  logic rst;
  logic S0, S1, Cout0, Cout1;
  logic A0, A1, B0, B1, Cin;

  int tests_run;
  int tests_failed;

  logic [3:0] exp_q[$];
  string      name_q[$];

  two_bit_adder dut (
    .clk   (clk),
    .rst   (rst),
    .S0    (S0),
    .S1    (S1),
    .Cout0 (Cout0),
    .Cout1 (Cout1),
    .A0    (A0),
    .A1    (A1),
    .B0    (B0),
    .B1    (B1),
    .Cin   (Cin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge so each vector is stable for the next rising edge.
  task automatic drive(input logic r, input logic [1:0] a, input logic [1:0] b,
                       input logic ci, input logic [3:0] exp, input string nm);
    @(negedge clk);
    rst = r;
    A1 = a[1]; A0 = a[0];
    B1 = b[1]; B0 = b[0];
    Cin = ci;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    logic [3:0] got;
    logic [3:0] exp;
    string      nm;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {Cout1, Cout0, S1, S0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL %s: got {Cout1,Cout0,S1,S0}=%b expected %b", nm, got, exp);
      end
    end
  end

  initial begin
    logic [1:0] a, b;
    logic       ci;
    logic [2:0] total;
    logic       maj0;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    A0 = 1'b0; A1 = 1'b0; B0 = 1'b0; B1 = 1'b0; Cin = 1'b0;

    drive(1'b1, 2'b11, 2'b11, 1'b1, 4'b0000, "reset_edge1");
    drive(1'b1, 2'b11, 2'b11, 1'b1, 4'b0000, "reset_edge2");

    for (int i = 0; i < 32; i++) begin
      ci    = i[4];
      a     = i[3:2];
      b     = i[1:0];
      total = 3'(a) + 3'(b) + 3'(ci);
      maj0  = (2'(a[0]) + 2'(b[0]) + 2'(ci)) >= 2'd2;
      drive(1'b0, a, b, ci, {total[2], maj0, total[1:0]}, $sformatf("sweep_%0d", i));
    end

    drive(1'b0, 2'b01, 2'b01, 1'b0, 4'b0110, "spot_01_01_0");
    drive(1'b0, 2'b11, 2'b11, 1'b1, 4'b1111, "spot_11_11_1");
    drive(1'b0, 2'b10, 2'b01, 1'b1, 4'b1100, "full_ripple");

    drive(1'b0, 2'b00, 2'b00, 1'b0, 4'b0000, "latency_pre");
    drive(1'b0, 2'b11, 2'b00, 1'b0, 4'b0011, "latency_post");
    #2;
    tests_run++;
    if ({Cout1, Cout0, S1, S0} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL latency_hold: got %b before edge, expected 0000", {Cout1, Cout0, S1, S0});
    end

    drive(1'b0, 2'b11, 2'b01, 1'b0, 4'b1100, "midrst_before");
    drive(1'b1, 2'b11, 2'b01, 1'b0, 4'b0000, "midrst_asserted");
    drive(1'b0, 2'b11, 2'b01, 1'b0, 4'b1100, "midrst_released");

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() > 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expected responses never checked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
